// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, execute redirect
// input, and the fetch/decode output stage with its valid/ready handshake.
//   master : the fetch unit (drives imem_addr and the if_* stage)
//   slave  : the environment (memory, execute, decoder)
interface pc_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_instr, redirect_valid, redirect_target, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_instr, redirect_valid, redirect_target, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end. Holds the PC, drives the instruction memory
// read address, and registers the returned word into a fetch/decode stage
// handshaked toward the decoder. Redirects from execute flush the stage;
// misaligned redirect targets and out-of-range fetches are flagged.
// Ports:
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   fetch_if       memory / redirect / decode-stage bundle (master side)
//   misalign_err_o sticky: a redirect target had nonzero bits [1:0]
//   fetch_fault_o  pc left the fetchable space; fetching stopped
//   fetch_count_o  completed if_valid && if_ready handshakes (wraps)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0004,
  parameter logic [31:0] IMEM_BYTES = 32'd64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.master  fetch_if,
  output logic             misalign_err_o,
  output logic             fetch_fault_o,
  output logic [31:0]      fetch_count_o
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic stage_free;
  logic in_range;
  logic load;
  logic handshake;

  assign stage_free = !valid_q || fetch_if.if_ready;
  assign in_range   = pc_q < IMEM_BYTES;
  assign load       = stage_free && !fault_q && in_range;
  assign handshake  = valid_q && fetch_if.if_ready;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;
    // The held instruction is consumed before any flush, so a redirect
    // cycle still counts its handshake.
    count_d    = handshake ? count_q + 32'd1 : count_q;

    if (fetch_if.redirect_valid) begin
      // Target is forced word-aligned; the misalignment is only recorded.
      pc_d       = {fetch_if.redirect_target[31:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      misalign_d = misalign_q | (fetch_if.redirect_target[1:0] != 2'b00);
      fault_d    = 1'b0;
    end else if (!in_range && stage_free) begin
      fault_d = 1'b1;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d  = fetch_if.imem_instr;
      if_pc_d  = pc_q;
      if_pc4_d = pc_q + 32'd4;
      valid_d  = 1'b1;
      pc_d     = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      if_pc_q    <= 32'd0;
      if_pc4_q   <= 32'd0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign fetch_if.imem_addr   = pc_q;
  assign fetch_if.if_valid    = valid_q;
  // A stage emptied by a fault keeps its old word in instr_q; the decoder
  // must still see a NOP whenever nothing valid is held.
  assign fetch_if.if_instr    = valid_q ? instr_q : NOP_INSTR;
  assign fetch_if.if_pc       = if_pc_q;
  assign fetch_if.if_pc_plus4 = if_pc4_q;
  assign misalign_err_o       = misalign_q;
  assign fetch_fault_o        = fault_q;
  assign fetch_count_o        = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        misalign_err;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_if       (bus),
    .misalign_err_o (misalign_err),
    .fetch_fault_o  (fetch_fault),
    .fetch_count_o  (fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  assign bus.imem_instr = (bus.imem_addr < 32'd64) ? mem[bus.imem_addr[5:2]] : 32'hDEAD_BEEF;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_count;
    logic        exp_fault;
    logic        exp_mis;
  } vec_t;

  vec_t        vt [$];
  logic [31:0] sb_pc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic ready, input logic redir, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic [31:0] ecnt, input logic ef, input logic em);
    vec_t v;
    v.ready = ready; v.redir = redir; v.tgt = tgt; v.exp_valid = ev; v.exp_pc = epc;
    v.exp_addr = eaddr; v.exp_count = ecnt; v.exp_fault = ef; v.exp_mis = em;
    vt.push_back(v);
  endtask

  // Inputs are stable here; a handshake pending at the coming edge is popped
  // from the scoreboard and compared against the word the decoder takes.
  task automatic tick();
    logic [31:0] epc;
    if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
      if (sb_pc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_handshake actual_pc=%h required=none", bus.if_pc);
      end else begin
        epc = sb_pc.pop_front();
        chk("sb_if_pc", bus.if_pc, epc);
        chk("sb_if_instr", bus.if_instr, mem[epc[5:2]]);
        chk("sb_if_pc_plus4", bus.if_pc_plus4, epc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {16'hA5A5, 8'(i), 8'h13};
    mem[1] = 32'h0050_0113;
    mem[2] = 32'h00c0_0193;

    bus.if_ready        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;

    // reset state, held across clock edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
    chk("rst_imem_addr", bus.imem_addr, 32'h4);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_pc_plus4", bus.if_pc_plus4, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;

    //  ready redir tgt       valid pc        addr      count  fault mis
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h08, 32'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C, 32'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10, 32'd2, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10, 32'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'h14, 32'd3, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h14, 32'h18, 32'd4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 32'h3C, 1'b0, 32'h00, 32'h3C, 32'd5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h3C, 32'h40, 32'd5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h40, 32'd6, 1'b1, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h40, 32'd6, 1'b1, 1'b0);
    add(1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h04, 32'd6, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h08, 32'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 32'h2E, 1'b0, 32'h00, 32'h2C, 32'd7, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h2C, 32'h30, 32'd7, 1'b0, 1'b1);
    add(1'b1, 1'b1, 32'h10, 1'b0, 32'h00, 32'h10, 32'd8, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'h14, 32'd8, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h80, 1'b0, 32'h00, 32'h80, 32'd8, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h80, 32'd8, 1'b1, 1'b1);
    add(1'b0, 1'b1, 32'h08, 1'b0, 32'h00, 32'h08, 32'd8, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C, 32'd8, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C, 32'd8, 1'b0, 1'b1);

    // words the decoder should accept, in order
    sb_pc = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h3C, 32'h04, 32'h2C};

    foreach (vt[i]) begin
      bus.if_ready        = vt[i].ready;
      bus.redirect_valid  = vt[i].redir;
      bus.redirect_target = vt[i].tgt;
      tick();
      bus.redirect_valid  = 1'b0;
      chk($sformatf("v%0d_if_valid", i), {31'd0, bus.if_valid}, {31'd0, vt[i].exp_valid});
      chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_count", i), fetch_count, vt[i].exp_count);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vt[i].exp_fault});
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign_err}, {31'd0, vt[i].exp_mis});
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d_if_pc", i), bus.if_pc, vt[i].exp_pc);
        chk($sformatf("v%0d_if_instr", i), bus.if_instr, mem[vt[i].exp_pc[5:2]]);
      end else begin
        chk($sformatf("v%0d_if_instr_nop", i), bus.if_instr, 32'h0000_0013);
      end
    end
    chk("sb_drained", sb_pc.size(), 32'd0);

    // async reset in the middle of a stall, away from any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("arst_if_instr", bus.if_instr, 32'h0000_0013);
    chk("arst_imem_addr", bus.imem_addr, 32'h4);
    chk("arst_if_pc", bus.if_pc, 32'h0);
    chk("arst_count", fetch_count, 32'h0);
    chk("arst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);

    // restart: first word one edge after release
    @(negedge clk);
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    tick();
    chk("restart_if_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("restart_if_pc", bus.if_pc, 32'h4);
    chk("restart_if_instr", bus.if_instr, 32'h0050_0113);
    chk("restart_if_pc_plus4", bus.if_pc_plus4, 32'h8);
    chk("restart_imem_addr", bus.imem_addr, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
